multi_dataflow_offs_gen: RTL

//  Nested-loop offset generator feeding the multi_dataflow control FSM (ctrl_uloop_t/flags_uloop_t side).

---
 rtl/multi_dataflow_offs_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/multi_dataflow_offs_gen.sv
// Nested-loop offset generator: walks NB_LOOPS odometer counters and emits one offset per stream.
// Offsets are kept as per-loop accumulated products so only adders are needed.
module multi_dataflow_offs_gen #(
  parameter int unsigned NB_LOOPS   = 2,
  parameter int unsigned NB_STREAMS = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned OFFS_W     = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clear_i,
  input  logic                                  enable_i,
  input  logic [NB_LOOPS*CNT_W-1:0]             loop_range_i,
  input  logic [NB_LOOPS*NB_STREAMS*OFFS_W-1:0] stride_i,
  output logic                                  valid_o,
  output logic                                  done_o,
  output logic [NB_STREAMS*OFFS_W-1:0]          offs_o,
  output logic [NB_LOOPS*CNT_W-1:0]             idx_o
);

  typedef enum logic [1:0] {StReady, StUpdate, StDone} state_e;

  state_e                                              state_q;
  logic                                                valid_q, done_q;
  logic [NB_LOOPS-1:0][CNT_W-1:0]                      idx_q, idx_n, range_v, last_v;
  logic [NB_LOOPS-1:0][NB_STREAMS-1:0][OFFS_W-1:0]     acc_q, acc_n, stride_v;
  logic [NB_STREAMS-1:0][OFFS_W-1:0]                   offs_q, offs_n;
  logic                                                adv_found;
  int                                                  adv_lvl;

  assign range_v  = loop_range_i;
  assign stride_v = stride_i;

  // Odometer step: lowest loop not yet at its last index advances, lower loops restart.
  always_comb begin
    adv_found = 1'b0;
    adv_lvl   = 0;
    idx_n     = idx_q;
    acc_n     = acc_q;
    offs_n    = '0;
    for (int l = 0; l < int'(NB_LOOPS); l++) begin
      last_v[l] = (range_v[l] == '0) ? '0 : range_v[l] - CNT_W'(1);
    end
    for (int l = int'(NB_LOOPS) - 1; l >= 0; l--) begin
      if (idx_q[l] < last_v[l]) begin
        adv_found = 1'b1;
        adv_lvl   = l;
      end
    end
    for (int l = 0; l < int'(NB_LOOPS); l++) begin
      if (adv_found && l == adv_lvl) begin
        idx_n[l] = idx_q[l] + CNT_W'(1);
        for (int s = 0; s < int'(NB_STREAMS); s++) begin
          acc_n[l][s] = acc_q[l][s] + stride_v[l][s];
        end
      end else if (adv_found && l < adv_lvl) begin
        idx_n[l] = '0;
        acc_n[l] = '0;
      end
    end
    for (int s = 0; s < int'(NB_STREAMS); s++) begin
      for (int l = 0; l < int'(NB_LOOPS); l++) begin
        offs_n[s] = offs_n[s] + acc_n[l][s];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StReady;
      idx_q   <= '0;
      acc_q   <= '0;
      offs_q  <= '0;
      valid_q <= 1'b1;
      done_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= StReady;
      idx_q   <= '0;
      acc_q   <= '0;
      offs_q  <= '0;
      valid_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StReady: begin
          if (enable_i) begin
            state_q <= StUpdate;
            valid_q <= 1'b0;
          end
        end
        StUpdate: begin
          valid_q <= 1'b1;
          if (adv_found) begin
            state_q <= StReady;
            idx_q   <= idx_n;
            acc_q   <= acc_n;
            offs_q  <= offs_n;
          end else begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: ;
        default: begin
          state_q <= StReady;
          valid_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign offs_o  = offs_q;
  assign idx_o   = idx_q;

endmodule
